pc_memory_controller: RTL and testbench

Parametrised program-counter and unified-memory subsystem for the MERC-16 multicycle datapath. It holds the PC, selects the next PC from four sources, and performs instruction fetches and data loads/stores through a request/done handshake with a configurable number of wait states. Results land in the instruction register (`Instruction`) and the memory data register (`RegData`). It sits between the control FSM, the ALU/register file and the rest of the datapath.

---
 rtl/pc_memory_controller.sv | 169 ++++++++++++++++
 tb/tb_pc_memory_controller.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_memory_controller.sv
// MERC-16 program counter plus unified instruction/data memory with a request/done handshake.
// Optional feature: define PCMEM_ALIGN_CHECK_EN to reject odd byte addresses with a one-cycle Fault pulse.
module pc_memory_controller #(
    parameter int    DATA_WIDTH  = 16,
    parameter int    ADDR_WIDTH  = 10,
    parameter int    JUMP_WIDTH  = 11,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [JUMP_WIDTH-1:0] JumpImmediate,
    input  logic [DATA_WIDTH-1:0] ALU_Out,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic [1:0]            PC_Source,
    input  logic                  PC_Write,
    input  logic                  Request,
    input  logic                  InstData,
    input  logic                  MemWrite,
    input  logic                  IR_Write,
    output logic [DATA_WIDTH-1:0] PC_Out,
    output logic [DATA_WIDTH-1:0] RegData,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Fault
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                state;
    logic [3:0]            count;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic [ADDR_WIDTH-1:0] cap_idx;
    logic [DATA_WIDTH-1:0] cap_data;
    logic                  cap_write;
    logic                  cap_ir;
    logic [DATA_WIDTH-1:0] reg_data;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  busy;
    logic                  done;
    logic                  can_accept;
    logic                  misaligned;
    logic                  start;
    logic                  complete;
    logic                  unused_addr_bits;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_comb begin
        pc_next = pc + DATA_WIDTH'(2);
        case (PC_Source)
            2'd0: pc_next = pc + DATA_WIDTH'(2);
            2'd1: pc_next = ALU_Out;
            2'd2: pc_next = {pc[DATA_WIDTH-1:JUMP_WIDTH+1], JumpImmediate, 1'b0};
            2'd3: pc_next = SrcA;
            default: pc_next = pc + DATA_WIDTH'(2);
        endcase
    end

    // A fetch always uses the PC as it stands before any same-edge update.
    assign req_addr = InstData ? ALU_Out : pc;
    assign req_idx  = req_addr[ADDR_WIDTH:1];
    assign unused_addr_bits = ^{req_addr[DATA_WIDTH-1:ADDR_WIDTH+1], req_addr[0]};

`ifdef PCMEM_ALIGN_CHECK_EN
    assign misaligned = req_addr[0];
`else
    assign misaligned = 1'b0;
`endif

    // The completion edge also accepts a new request so back-to-back accesses
    // sustain one access every WAIT_STATES+1 cycles.
    assign complete   = (state == ACCESS) && (count == 4'd0);
    assign can_accept = (state == IDLE) || complete;
    assign start      = Request && can_accept && !misaligned;

    // NOTE: the memory array has no reset; contents survive Reset, and the write
    // is gated by Reset so an access aborted by reset never commits.
    always_ff @(posedge Clock) begin
        if (Reset && complete && cap_write) begin
            mem[cap_idx] <= cap_data;
        end
    end

    // NOTE: every sequential assignment is non-blocking; later assignments in
    // this block deliberately override earlier ones (chained start after completion).
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state       <= IDLE;
            count       <= 4'd0;
            pc          <= '0;
            cap_idx     <= '0;
            cap_data    <= '0;
            cap_write   <= 1'b0;
            cap_ir      <= 1'b0;
            reg_data    <= '0;
            instruction <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (PC_Write) pc <= pc_next;

            case (state)
                IDLE: begin
                end
                ACCESS: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        if (cap_write) begin
                            reg_data <= cap_data;
                        end else begin
                            reg_data <= mem[cap_idx];
                            if (cap_ir) instruction <= mem[cap_idx];
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (start) begin
                cap_idx   <= req_idx;
                cap_data  <= SrcB;
                cap_write <= MemWrite;
                cap_ir    <= IR_Write && !InstData;
                count     <= 4'(WAIT_STATES);
                busy      <= 1'b1;
                state     <= ACCESS;
            end
        end
    end

`ifdef PCMEM_ALIGN_CHECK_EN
    logic fault;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            fault <= 1'b0;
        end else begin
            fault <= Request && can_accept && misaligned;
        end
    end

    assign Fault = fault;
`else
    assign Fault = 1'b0;
`endif

    assign PC_Out      = pc;
    assign RegData     = reg_data;
    assign Instruction = instruction;
    assign Busy        = busy;
    assign Done        = done;

endmodule

// File: tb/tb_pc_memory_controller.sv
// Directed bench for pc_memory_controller: PC-source vector table plus hand-written access sequences.
// Two instances: WAIT_STATES=1 for the functional tests and WAIT_STATES=3 for handshake timing.
module tb_pc_memory_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] jump_imm;
    logic [15:0] alu_out;
    logic [15:0] src_a;
    logic [15:0] src_b;
    logic [1:0]  pc_src;
    logic        pc_write;
    logic        req;
    logic        req3;
    logic        inst_data;
    logic        mem_write;
    logic        ir_write;

    logic [15:0] pc_out, reg_data, instr;
    logic        busy, done, fault;
    logic [15:0] pc_out3, reg_data3, instr3;
    logic        busy3, done3, fault3;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pc_memory_controller #(.WAIT_STATES(1)) dut (
        .Clock(clk), .Reset(rst_n), .JumpImmediate(jump_imm), .ALU_Out(alu_out),
        .SrcA(src_a), .SrcB(src_b), .PC_Source(pc_src), .PC_Write(pc_write),
        .Request(req), .InstData(inst_data), .MemWrite(mem_write), .IR_Write(ir_write),
        .PC_Out(pc_out), .RegData(reg_data), .Instruction(instr),
        .Busy(busy), .Done(done), .Fault(fault)
    );

    pc_memory_controller #(.WAIT_STATES(3)) dut3 (
        .Clock(clk), .Reset(rst_n), .JumpImmediate(jump_imm), .ALU_Out(alu_out),
        .SrcA(src_a), .SrcB(src_b), .PC_Source(pc_src), .PC_Write(pc_write),
        .Request(req3), .InstData(inst_data), .MemWrite(mem_write), .IR_Write(ir_write),
        .PC_Out(pc_out3), .RegData(reg_data3), .Instruction(instr3),
        .Busy(busy3), .Done(done3), .Fault(fault3)
    );

    typedef struct {
        logic [1:0]  src;
        logic [15:0] alu;
        logic [15:0] srca;
        logic [10:0] jimm;
        logic [15:0] exp_pc;
    } pc_vec_t;

    pc_vec_t pv [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit use3, output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if ((use3 ? done3 : done) === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic access(input logic instd, input logic mw, input logic irw,
                          input logic [15:0] addr, input logic [15:0] data, input string name);
        int lat;
        inst_data = instd;
        mem_write = mw;
        ir_write  = irw;
        alu_out   = addr;
        src_b     = data;
        req       = 1'b1;
        tick();
        req = 1'b0;
        check({name, "_busy"}, busy, 1);
        wait_done(1'b0, lat);
        check({name, "_latency"}, lat, 2);
        check({name, "_busy_after"}, busy, 0);
    endtask

    task automatic access3(input logic mw, input logic [15:0] addr, input logic [15:0] data,
                           input string name);
        int lat;
        inst_data = 1'b1;
        mem_write = mw;
        ir_write  = 1'b0;
        alu_out   = addr;
        src_b     = data;
        req3      = 1'b1;
        tick();
        req3 = 1'b0;
        wait_done(1'b1, lat);
        check({name, "_latency"}, lat, 4);
    endtask

    task automatic set_pc(input logic [15:0] value);
        pc_src   = 2'd1;
        alu_out  = value;
        pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;

        pv[0] = '{src: 2'd1, alu: 16'h1234, srca: 16'h0000, jimm: 11'h000, exp_pc: 16'h1234};
        pv[1] = '{src: 2'd0, alu: 16'h0000, srca: 16'h0000, jimm: 11'h000, exp_pc: 16'h1236};
        pv[2] = '{src: 2'd1, alu: 16'hFFFE, srca: 16'h0000, jimm: 11'h000, exp_pc: 16'hFFFE};
        pv[3] = '{src: 2'd0, alu: 16'h0000, srca: 16'h0000, jimm: 11'h000, exp_pc: 16'h0000};
        pv[4] = '{src: 2'd1, alu: 16'hF000, srca: 16'h0000, jimm: 11'h000, exp_pc: 16'hF000};
        pv[5] = '{src: 2'd2, alu: 16'h0000, srca: 16'h0000, jimm: 11'h3FF, exp_pc: 16'hF7FE};
        pv[6] = '{src: 2'd3, alu: 16'h0000, srca: 16'hBEEF, jimm: 11'h000, exp_pc: 16'hBEEF};
        pv[7] = '{src: 2'd2, alu: 16'h0000, srca: 16'h0000, jimm: 11'h001, exp_pc: 16'hB002};
        pv[8] = '{src: 2'd0, alu: 16'h0000, srca: 16'h0000, jimm: 11'h000, exp_pc: 16'hB004};

        rst_n     = 1'b0;
        jump_imm  = '0;
        alu_out   = '0;
        src_a     = '0;
        src_b     = '0;
        pc_src    = 2'd0;
        pc_write  = 1'b0;
        req       = 1'b0;
        req3      = 1'b0;
        inst_data = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        tick();
        tick();
        check("reset_pc", pc_out, 0);
        check("reset_instr", instr, 0);
        check("reset_regdata", reg_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_fault", fault, 0);
        rst_n = 1'b1;
        tick();

        // PC source table
        for (int i = 0; i < 9; i++) begin
            pc_src   = pv[i].src;
            alu_out  = pv[i].alu;
            src_a    = pv[i].srca;
            jump_imm = pv[i].jimm;
            pc_write = 1'b1;
            tick();
            pc_write = 1'b0;
            check($sformatf("pc_vec%0d", i), pc_out, pv[i].exp_pc);
        end

        // Fill words 0..8 with i+1 through stores, checking write-through
        for (int i = 0; i < 9; i++) begin
            access(1'b1, 1'b1, 1'b0, 16'(2 * i), 16'(i + 1), "store");
            check($sformatf("store%0d_regdata", i), reg_data, i + 1);
        end

        // Fetch sweep
        for (int i = 0; i < 9; i++) begin
            set_pc(16'(2 * i));
            access(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, "fetch");
            check($sformatf("fetch%0d_instr", i), instr, i + 1);
            check($sformatf("fetch%0d_regdata", i), reg_data, i + 1);
            check($sformatf("fetch%0d_fault", i), fault, 0);
        end

        // Store then load; data accesses leave Instruction alone
        access(1'b1, 1'b1, 1'b0, 16'd20, 16'd5, "st20");
        check("st20_regdata", reg_data, 5);
        check("st20_instr", instr, 9);
        access(1'b1, 1'b0, 1'b0, 16'd20, 16'd0, "ld20");
        check("ld20_regdata", reg_data, 5);
        check("ld20_instr", instr, 9);
        access(1'b1, 1'b0, 1'b0, 16'h0814, 16'd0, "ld_alias");
        check("ld_alias_regdata", reg_data, 5);
        access(1'b1, 1'b0, 1'b1, 16'd2, 16'd0, "ld_irw_data");
        check("ld_irw_data_regdata", reg_data, 2);
        check("ld_irw_data_instr", instr, 9);

        // PC_Write together with a fetch request: fetch uses old PC
        set_pc(16'h0004);
        pc_src    = 2'd1;
        alu_out   = 16'h0010;
        pc_write  = 1'b1;
        inst_data = 1'b0;
        ir_write  = 1'b1;
        mem_write = 1'b0;
        req       = 1'b1;
        tick();
        req      = 1'b0;
        pc_write = 1'b0;
        check("pcw_fetch_pc", pc_out, 16'h0010);
        wait_done(1'b0, lat);
        check("pcw_fetch_latency", lat, 2);
        check("pcw_fetch_instr", instr, 3);

        // Reset in the middle of a store to word 7
        inst_data = 1'b1;
        mem_write = 1'b1;
        ir_write  = 1'b0;
        alu_out   = 16'd14;
        src_b     = 16'h0055;
        req       = 1'b1;
        tick();
        req = 1'b0;
        check("abort_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_pc", pc_out, 0);
        check("abort_instr", instr, 0);
        check("abort_regdata", reg_data, 0);
        check("abort_busy_after", busy, 0);
        check("abort_done", done, 0);
        check("abort_fault", fault, 0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);
        access(1'b1, 1'b0, 1'b0, 16'd14, 16'd0, "ld14");
        check("ld14_regdata", reg_data, 8);

        // Odd data address
        inst_data = 1'b1;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        alu_out   = 16'h0003;
        req       = 1'b1;
        tick();
        req = 1'b0;
`ifdef PCMEM_ALIGN_CHECK_EN
        check("align_fault", fault, 1);
        check("align_busy", busy, 0);
        tick();
        check("align_fault_width", fault, 0);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (busy === 1'b1 || done === 1'b1) seen++;
            tick();
        end
        check("align_no_access", seen, 0);
        check("align_regdata", reg_data, 8);
`else
        check("odd_fault", fault, 0);
        check("odd_busy", busy, 1);
        wait_done(1'b0, lat);
        check("odd_latency", lat, 2);
        check("odd_regdata", reg_data, 2);
        check("odd_fault_after", fault, 0);
`endif

        // Handshake timing on the WAIT_STATES=3 instance
        access3(1'b1, 16'd4, 16'h0011, "hs_pre");
        check("hs_pre_regdata", reg_data3, 16'h0011);
        inst_data = 1'b1;
        mem_write = 1'b1;
        alu_out   = 16'd2;
        src_b     = 16'h0077;
        req3      = 1'b1;
        tick();
        check("hs_busy", busy3, 1);
        alu_out = 16'd4;
        src_b   = 16'h0099;
        tick();
        req3 = 1'b0;
        wait_done(1'b1, lat);
        check("hs_ignored_latency", lat, 3);
        check("hs_regdata", reg_data3, 16'h0077);
        check("hs_busy_after", busy3, 0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done3 === 1'b1) seen++;
        end
        check("hs_no_extra_done", seen, 0);

        mem_write = 1'b0;
        alu_out   = 16'd2;
        req3      = 1'b1;
        tick();
        wait_done(1'b1, lat);
        check("hs_held_first_latency", lat, 4);
        check("hs_held_first_regdata", reg_data3, 16'h0077);
        req3 = 1'b0;
        wait_done(1'b1, lat);
        check("hs_b2b_gap", lat, 4);
        check("hs_b2b_regdata", reg_data3, 16'h0077);
        access3(1'b0, 16'd4, 16'h0000, "hs_word4");
        check("hs_word4_regdata", reg_data3, 16'h0011);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
